// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer between the pipeline and the CSR file.
// It prioritises exceptions and interrupts, drains bus traffic, commits to the CSRs and redirects fetch.
//
// Ports:
//   clock/reset
//     i_clk, i_rst (async, active-low)
//   instruction context
//     i_pc, i_inst, i_badaddr
//   synchronous exceptions
//     i_ex_inst_addr, i_ex_illegal, i_ex_ebreak
//     i_ex_ecall, i_ex_st_addr, i_ex_ld_addr
//   MRET
//     i_mret, i_mepc
//   interrupts
//     i_mstatus_mie, i_mie_mask {MEIE,MTIE,MSIE}
//     i_meip, i_mtip, i_msip
//   bus / CSR
//     i_bus_busy, i_tvec
//   outputs
//     o_stall, o_flush, o_trap, o_cause, o_epc, o_tval
//     o_eret, o_redirect, o_redirect_pc, o_drain_tmo
//
// Build option: when TRAP_VECTORED_EN is defined and mtvec mode is vectored (i_tvec[1:0] == 2'b01),
// an interrupt goes to base + 4*cause. Exceptions always go to base.
module trap_ctrl #(
    parameter int XLEN      = 32,
    parameter int DRAIN_MAX = 15
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_badaddr,
    input  logic            i_ex_inst_addr,
    input  logic            i_ex_illegal,
    input  logic            i_ex_ebreak,
    input  logic            i_ex_ecall,
    input  logic            i_ex_st_addr,
    input  logic            i_ex_ld_addr,
    input  logic            i_mret,
    input  logic            i_mstatus_mie,
    input  logic [2:0]      i_mie_mask,
    input  logic            i_meip,
    input  logic            i_mtip,
    input  logic            i_msip,
    input  logic            i_bus_busy,
    input  logic [XLEN-1:0] i_tvec,
    input  logic [XLEN-1:0] i_mepc,
    output logic            o_stall,
    output logic            o_flush,
    output logic            o_trap,
    output logic [XLEN-1:0] o_cause,
    output logic [XLEN-1:0] o_epc,
    output logic [XLEN-1:0] o_tval,
    output logic            o_eret,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_drain_tmo
);

    localparam int CW = $clog2(DRAIN_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_COMMIT,
        S_REDIR
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            eret_q, eret_d;

    logic            ex_hit;
    logic [3:0]      ex_code;
    logic [XLEN-1:0] ex_tval;
    logic [2:0]      irq_v;
    logic            irq_hit;
    logic [3:0]      irq_code;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] irq_tgt;
    logic            drain_last;

    // Exception priority: inst_addr > illegal > ebreak > ecall > st_addr > ld_addr
    always_comb begin
        ex_hit  = 1'b1;
        ex_code = 4'd0;
        ex_tval = '0;
        priority case (1'b1)
            i_ex_inst_addr: begin
                ex_code = 4'd0;
                ex_tval = i_badaddr;
            end
            i_ex_illegal: begin
                ex_code = 4'd2;
                ex_tval = XLEN'(i_inst);
            end
            i_ex_ebreak: begin
                ex_code = 4'd3;
                ex_tval = i_pc;
            end
            i_ex_ecall: begin
                ex_code = 4'd11;
            end
            i_ex_st_addr: begin
                ex_code = 4'd6;
                ex_tval = i_badaddr;
            end
            i_ex_ld_addr: begin
                ex_code = 4'd4;
                ex_tval = i_badaddr;
            end
            default: ex_hit = 1'b0;
        endcase
    end

    // Interrupt bit order is {MEI, MTI, MSI}; MSI outranks MTI
    assign irq_v = {i_meip, i_mtip, i_msip} & i_mie_mask & {3{i_mstatus_mie}};
    assign irq_hit = |irq_v;

    always_comb begin
        irq_code = 4'd0;
        priority case (1'b1)
            irq_v[2]: irq_code = 4'd11;
            irq_v[0]: irq_code = 4'd3;
            irq_v[1]: irq_code = 4'd7;
            default:  irq_code = 4'd0;
        endcase
    end

    assign tvec_base = i_tvec & ~XLEN'(3);

`ifdef TRAP_VECTORED_EN
    assign irq_tgt = (i_tvec[1:0] == 2'b01)
                   ? tvec_base + {{(XLEN-6){1'b0}}, irq_code, 2'b00}
                   : tvec_base;
`else
    assign irq_tgt = tvec_base;
`endif

    assign drain_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        tval_d  = tval_q;
        tgt_d   = tgt_q;
        eret_d  = eret_q;
        unique case (state_q)
            S_IDLE: begin
                if (ex_hit) begin
                    cause_d = {1'b0, {(XLEN-5){1'b0}}, ex_code};
                    epc_d   = i_pc;
                    tval_d  = ex_tval;
                    tgt_d   = tvec_base;
                    eret_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else if (irq_hit) begin
                    cause_d = {1'b1, {(XLEN-5){1'b0}}, irq_code};
                    epc_d   = i_pc;
                    tval_d  = '0;
                    tgt_d   = irq_tgt;
                    eret_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else if (i_mret) begin
                    tgt_d   = i_mepc & ~XLEN'(3);
                    eret_d  = 1'b1;
                    state_d = S_REDIR;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                // The last allowed drain cycle forces the commit
                if (!i_bus_busy || drain_last) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: state_d = S_REDIR;
            S_REDIR:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
            tgt_q   <= '0;
            eret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
            tgt_q   <= tgt_d;
            eret_q  <= eret_d;
        end
    end

    assign o_stall       = (state_q != S_IDLE);
    assign o_trap        = (state_q == S_COMMIT);
    assign o_flush       = (state_q == S_COMMIT);
    assign o_redirect    = (state_q == S_REDIR);
    assign o_eret        = (state_q == S_REDIR) && eret_q;
    assign o_redirect_pc = (state_q == S_REDIR) ? tgt_q : '0;
    assign o_drain_tmo   = (state_q == S_DRAIN) && i_bus_busy && drain_last;
    assign o_cause       = cause_q;
    assign o_epc         = epc_q;
    assign o_tval        = tval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed self-checking bench for trap_ctrl.
// Walks through the trap, priority, drain-timeout, MRET and reset sequences.
module tb_trap_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc, inst, badaddr, tvec, mepc;
    logic        ex_ia, ex_il, ex_eb, ex_ec, ex_sa, ex_la;
    logic        mret, mie;
    logic [2:0]  mask;
    logic        meip, mtip, msip, busy;
    logic        stall, flush, trap, eret, redir, tmo;
    logic [31:0] cause, epc, tval, rpc;

    int total = 0;
    int fails = 0;

    trap_ctrl #(.XLEN(32), .DRAIN_MAX(15)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_pc(pc), .i_inst(inst), .i_badaddr(badaddr),
        .i_ex_inst_addr(ex_ia), .i_ex_illegal(ex_il),
        .i_ex_ebreak(ex_eb), .i_ex_ecall(ex_ec),
        .i_ex_st_addr(ex_sa), .i_ex_ld_addr(ex_la),
        .i_mret(mret), .i_mstatus_mie(mie), .i_mie_mask(mask),
        .i_meip(meip), .i_mtip(mtip), .i_msip(msip),
        .i_bus_busy(busy), .i_tvec(tvec), .i_mepc(mepc),
        .o_stall(stall), .o_flush(flush), .o_trap(trap),
        .o_cause(cause), .o_epc(epc), .o_tval(tval),
        .o_eret(eret), .o_redirect(redir),
        .o_redirect_pc(rpc), .o_drain_tmo(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ev();
        ex_ia = 0; ex_il = 0; ex_eb = 0; ex_ec = 0; ex_sa = 0; ex_la = 0;
        mret = 0; meip = 0; mtip = 0; msip = 0;
    endtask

    logic [31:0] vec_exp;

    initial begin
        rst = 0; pc = 0; inst = 0; badaddr = 0; tvec = 32'h80; mepc = 0;
        mie = 0; mask = 3'b000; busy = 0;
        clr_ev();
        // reset state
        #12;
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_trap", {31'd0, trap}, 0);
        chk("rst_redir", {31'd0, redir}, 0);
        chk("rst_cause", cause, 0);
        chk("rst_rpc", rpc, 0);
        chk("rst_tmo", {31'd0, tmo}, 0);
        step();
        rst = 1;
        step();

        // illegal instruction
        pc = 32'h100; inst = 32'hFFFF_FFFF; tvec = 32'h80; ex_il = 1;
        chk("il_N_stall", {31'd0, stall}, 0);
        step(); clr_ev();
        chk("il_N1_stall", {31'd0, stall}, 1);
        chk("il_N1_trap", {31'd0, trap}, 0);
        step();
        chk("il_N2_trap", {31'd0, trap}, 1);
        chk("il_N2_flush", {31'd0, flush}, 1);
        chk("il_cause", cause, 32'd2);
        chk("il_epc", epc, 32'h100);
        chk("il_tval", tval, 32'hFFFF_FFFF);
        step();
        chk("il_N3_redir", {31'd0, redir}, 1);
        chk("il_N3_trap", {31'd0, trap}, 0);
        chk("il_N3_eret", {31'd0, eret}, 0);
        chk("il_N3_rpc", rpc, 32'h80);
        step();
        chk("il_N4_stall", {31'd0, stall}, 0);
        chk("il_hold_cause", cause, 32'd2);

        // load misaligned beats enabled timer interrupt
        pc = 32'h200; badaddr = 32'h203; ex_la = 1;
        mtip = 1; mask = 3'b010; mie = 1;
        step(); clr_ev();
        step();
        chk("ld_trap", {31'd0, trap}, 1);
        chk("ld_cause", cause, 32'd4);
        chk("ld_tval", tval, 32'h203);
        step(); step();
        chk("ld_idle", {31'd0, stall}, 0);

        // timer interrupt
        pc = 32'h40; tvec = 32'h81; mtip = 1;
        step(); clr_ev();
        step();
        chk("mti_trap", {31'd0, trap}, 1);
        chk("mti_cause", cause, 32'h8000_0007);
        chk("mti_epc", epc, 32'h40);
        chk("mti_tval", tval, 32'h0);
        step();
`ifdef TRAP_VECTORED_EN
        vec_exp = 32'h9C;
`else
        vec_exp = 32'h80;
`endif
        chk("mti_rpc", rpc, vec_exp);
        step();
        tvec = 32'h80;

        // MEI outranks MSI
        meip = 1; msip = 1; mask = 3'b111;
        step(); clr_ev();
        step();
        chk("mei_cause", cause, 32'h8000_000B);
        step(); step();

        // interrupt ignored when mstatus.MIE is clear
        mie = 0; msip = 1;
        step();
        chk("nomie_stall", {31'd0, stall}, 0);
        clr_ev(); mie = 1;

        // inst_addr beats illegal and MRET
        pc = 32'h60; badaddr = 32'h11; ex_ia = 1; ex_il = 1; mret = 1;
        step(); clr_ev();
        chk("pri_drain_redir", {31'd0, redir}, 0);
        step();
        chk("pri_cause", cause, 32'd0);
        chk("pri_tval", tval, 32'h11);
        step();
        chk("pri_eret", {31'd0, eret}, 0);
        step();

        // drain timeout with bus busy
        pc = 32'h300; ex_ec = 1; busy = 1;
        step(); clr_ev();
        for (int i = 1; i <= 14; i++) begin
            chk($sformatf("tmo_c%0d_trap", i), {31'd0, trap}, 0);
            chk($sformatf("tmo_c%0d_tmo", i), {31'd0, tmo}, 0);
            step();
        end
        chk("tmo_c15_tmo", {31'd0, tmo}, 1);
        chk("tmo_c15_trap", {31'd0, trap}, 0);
        step();
        chk("tmo_trap", {31'd0, trap}, 1);
        chk("tmo_pulse_end", {31'd0, tmo}, 0);
        chk("tmo_cause", cause, 32'd11);
        chk("tmo_tval", tval, 32'd0);
        busy = 0;
        step(); step();
        chk("tmo_idle", {31'd0, stall}, 0);

        // busy drops in third drain cycle
        pc = 32'h500; ex_eb = 1; busy = 1;
        step(); clr_ev();
        chk("bd_c1_trap", {31'd0, trap}, 0);
        step();
        chk("bd_c2_trap", {31'd0, trap}, 0);
        step();
        busy = 0;
        chk("bd_c3_trap", {31'd0, trap}, 0);
        chk("bd_c3_tmo", {31'd0, tmo}, 0);
        step();
        chk("bd_trap", {31'd0, trap}, 1);
        chk("bd_cause", cause, 32'd3);
        chk("bd_tval", tval, 32'h500);
        step(); step();

        // MRET
        mepc = 32'h1237; mret = 1;
        chk("mret_N_redir", {31'd0, redir}, 0);
        step(); clr_ev();
        chk("mret_redir", {31'd0, redir}, 1);
        chk("mret_eret", {31'd0, eret}, 1);
        chk("mret_rpc", rpc, 32'h1234);
        chk("mret_trap", {31'd0, trap}, 0);
        chk("mret_stall", {31'd0, stall}, 1);
        step();
        chk("mret_done", {31'd0, stall}, 0);
        chk("mret_trap2", {31'd0, trap}, 0);
        chk("mret_hold_cause", cause, 32'd3);

        // reset during drain
        pc = 32'h700; inst = 32'h1234_5678; ex_il = 1; busy = 1;
        step(); clr_ev();
        chk("ar_drain", {31'd0, stall}, 1);
        #2 rst = 0;
        #1;
        chk("ar_stall", {31'd0, stall}, 0);
        chk("ar_trap", {31'd0, trap}, 0);
        chk("ar_cause", cause, 0);
        step();
        rst = 1; busy = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("ar_post%0d_trap", i), {31'd0, trap}, 0);
            chk($sformatf("ar_post%0d_stall", i), {31'd0, stall}, 0);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
